instruction_register: RTL and testbench
=======================================

// Module: instruction_register
// PURPOSE
//  - Holds the current 24-bit CPU instruction between fetch and decode in the 8-bit CPU datapath.
//  - Loads the instruction word on a clock edge when enable is high, and holds it otherwise.
//  - Presents the full word plus pre-split opcode/operand fields and a valid flag to the decoder.
// PARAMETERS
//  - WIDTH     24  total instruction width in bits; must equal OP_W + 2*ARG_W
//  - OP_W       8  opcode field width, located at bits [WIDTH-1 -: OP_W]
//  - ARG_W      8  width of each operand field (A in the middle, B in the LSBs)
//  - RESET_VAL  0  value of the instruction register after reset (NOP)
// PORTS
//  - clk          in   1      system clock; all state changes on rising edge
//  - rst_n        in   1      asynchronous, active-low reset
//  - in           in   WIDTH  instruction word from memory or fetch bus
//  - enable       in   1      load strobe; when high, in is captured at the next rising clk edge
//  - instruction  out  WIDTH  registered instruction word
//  - opcode       out  OP_W   instruction[23:16]
//  - operand_a    out  ARG_W  instruction[15:8]
//  - operand_b    out  ARG_W  instruction[7:0]
//  - valid        out  1      high once at least one load has occurred since reset
//  - loaded       out  1      one-cycle pulse in the cycle after a load
//  - prev_instr   out  WIDTH  only when IR_PREV_EN is defined: the word displaced by the last load
// BEHAVIOUR
//  - Reset (rst_n=0): asynchronous, independent of clk.
//    - instruction=RESET_VAL, valid=0, loaded=0, prev_instr=RESET_VAL.
//    - Reset dominates enable, including when asserted in the middle of a load cycle.
//  - Rising edge of clk with enable=1:
//    - instruction<=in, valid<=1, loaded<=1.
//    - Latency is 1 edge; the new value is visible immediately after that edge.
//  - Rising edge of clk with enable=0:
//    - instruction and valid hold; loaded<=0.
//    - Changes on in while enable=0 have no effect on any output.
//  - enable held high for N edges: reloads on every edge, so the register tracks in; loaded stays high.
//  - opcode, operand_a and operand_b are purely combinational slices of the instruction register.
//    - They never reflect in directly.
//  - valid is sticky: it clears only on reset, never on enable=0.
//  - in is sampled at the edge only; there is no combinational path from in or enable to any output.
//  - No X propagation from in is allowed while enable=0 (the register must not sample in).
// CONFIGURATION
//  - Macro IR_PREV_EN.
//  - Defined:
//    - Adds the prev_instr output and its register.
//    - On every load, prev_instr<=old instruction value, in the same edge that instruction<=in.
//    - prev_instr holds when enable=0 and resets to RESET_VAL.
//  - Undefined:
//    - The prev_instr port and its register are absent.
//    - All other behaviour is identical.
// TESTING
//  - Reset: rst_n=0, in=24'hFFFFFF, enable=1 -> instruction=0, valid=0, loaded=0.
//  - Hold before load: reset released, in=20, enable=0 for 2 edges -> instruction stays 0, valid=0.
//  - Load: enable=1, in=20 (24'h000014) -> after next edge instruction=20, opcode=0, operand_a=0,
//    operand_b=8'h14, valid=1, loaded=1.
//  - Hold after load: enable=0, in changes to 30 -> instruction remains 20, loaded=0, valid=1.
//  - Field split and back-to-back loads:
//    - enable=1, in=24'hA1B2C3 -> opcode=A1, operand_a=B2, operand_b=C3.
//    - Next edge with in=24'h123456 -> instruction=123456, loaded stays 1.
//    - With IR_PREV_EN: prev_instr=A1B2C3.
//  - Async reset mid-operation: load 24'h0F0F0F, then drop rst_n between edges ->
//    - instruction=0 and valid=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/instruction_register.sv
// rtl/instruction_register.sv - fetch-to-decode instruction register with field split (optional IR_PREV_EN history output)
module instruction_register #(
   parameter int unsigned             WIDTH     = 24,
   parameter int unsigned             OP_W      = 8,
   parameter int unsigned             ARG_W     = 8,
   parameter logic [WIDTH-1:0]        RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             enable,
   output logic [WIDTH-1:0] instruction,
   output logic [OP_W-1:0]  opcode,
   output logic [ARG_W-1:0] operand_a,
   output logic [ARG_W-1:0] operand_b,
   output logic             valid,
`ifdef IR_PREV_EN
   output logic [WIDTH-1:0] prev_instr,
`endif
   output logic             loaded
);

   // The field slices below assume the opcode and both operands exactly tile the word.
   generate
      if (WIDTH != OP_W + 2 * ARG_W) begin : g_bad_layout
         $error("instruction_register: WIDTH must equal OP_W + 2*ARG_W");
      end
   endgenerate

   logic [WIDTH-1:0] instruction_q;
   logic             valid_q;
   logic             loaded_q;

   // Main register: capture on enable, hold otherwise; in is never looked at when enable is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction_q <= RESET_VAL;
         valid_q       <= 1'b0;
         loaded_q      <= 1'b0;
      end else begin
         loaded_q <= enable;
         if (enable) begin
            instruction_q <= in;
            valid_q       <= 1'b1;
         end
      end
   end

`ifdef IR_PREV_EN
   logic [WIDTH-1:0] prev_q;

   // History register: keeps the word that the most recent load pushed out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= RESET_VAL;
      end else if (enable) begin
         prev_q <= instruction_q;
      end
   end

   assign prev_instr = prev_q;
`endif

   // Decoder-facing fields are slices of the register only, never of in.
   assign instruction = instruction_q;
   assign opcode      = instruction_q[WIDTH-1 -: OP_W];
   assign operand_a   = instruction_q[2*ARG_W-1 -: ARG_W];
   assign operand_b   = instruction_q[ARG_W-1:0];
   assign valid       = valid_q;
   assign loaded      = loaded_q;

endmodule

// File: tb/tb_instruction_register.sv
// tb/tb_instruction_register.sv - scoreboard bench for instruction_register
module tb_instruction_register;

   logic        clk;
   logic        rst_n;
   logic [23:0] in;
   logic        enable;
   logic [23:0] instruction;
   logic [7:0]  opcode;
   logic [7:0]  operand_a;
   logic [7:0]  operand_b;
   logic        valid;
   logic        loaded;
`ifdef IR_PREV_EN
   logic [23:0] prev_instr;
`endif

   instruction_register dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in          (in),
      .enable      (enable),
      .instruction (instruction),
      .opcode      (opcode),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .valid       (valid),
`ifdef IR_PREV_EN
      .prev_instr  (prev_instr),
`endif
      .loaded      (loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned word;
      int unsigned prev;
      bit          vld;
      bit          ld;
   } exp_t;

   exp_t        sb[$];
   int unsigned hist[$];
   bit          m_loaded;
   int          checks;
   int          failures;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: the register shows the last loaded word, the previous one is the word before it.
   function automatic exp_t model_now();
      exp_t e;
      e.vld  = (hist.size() > 0);
      e.word = e.vld ? hist[hist.size()-1] : 0;
      e.prev = (hist.size() > 1) ? hist[hist.size()-2] : 0;
      e.ld   = m_loaded;
      return e;
   endfunction

   task automatic step(input bit en, input int unsigned data);
      @(negedge clk);
      enable = en;
      in     = data[23:0];
      if (en) hist.push_back(data & 24'hFFFFFF);
      m_loaded = en;
      sb.push_back(model_now());
   endtask

   // Monitor: after each rising edge, compare outputs with the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("instruction", instruction, e.word);
            chk("opcode",      opcode,      (e.word / 65536) % 256);
            chk("operand_a",   operand_a,   (e.word / 256) % 256);
            chk("operand_b",   operand_b,   e.word % 256);
            chk("valid",       valid,       e.vld);
            chk("loaded",      loaded,      e.ld);
`ifdef IR_PREV_EN
            chk("prev_instr",  prev_instr,  e.prev);
`endif
         end
      end
   end

   initial begin
      int unsigned guard;
      checks   = 0;
      failures = 0;
      m_loaded = 0;
      rst_n    = 1'b0;
      in       = 24'hFFFFFF;
      enable   = 1'b1;

      // Reset dominates enable.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_instruction", instruction, 0);
      chk("rst_valid",       valid,       0);
      chk("rst_loaded",      loaded,      0);
      enable = 1'b0;
      rst_n  = 1'b1;

      // Hold before any load.
      step(0, 20);
      step(0, 20);
      // First load, then hold with a changed input.
      step(1, 20);
      step(0, 30);
      step(0, 30);
      // Field split and back-to-back loads.
      step(1, 24'hA1B2C3);
      step(1, 24'h123456);
      step(0, 24'h777777);

      for (int i = 0; i < 200; i++)
         step($urandom_range(0, 2) != 0, $urandom);

      // Asynchronous reset between edges.
      step(1, 24'h0F0F0F);
      @(posedge clk);
      #3;
      rst_n  = 1'b0;
      enable = 1'b0;
      #1;
      chk("async_instruction", instruction, 0);
      chk("async_valid",       valid,       0);
      chk("async_loaded",      loaded,      0);
      hist.delete();
      m_loaded = 0;
      @(negedge clk);
      rst_n = 1'b1;

      step(0, 24'hABCDEF);
      for (int i = 0; i < 100; i++)
         step($urandom_range(0, 1) != 0, $urandom);

      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #3;
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
